// File: rtl/udp_tx_arbiter.sv
// Shares one UDP/IP transmit engine between NUM_REQ frame sources: round-robin grant,
// length check, send_en start pulse, read/data steering, inter-frame gap and BUSY watchdog.
//
// state | meaning
// IDLE  | no frame in flight, waiting for any req
// ARB   | pick next requester from rr_ptr, latch len/port, check length
// START | grant held, issue send_en on exit
// BUSY  | engine transmitting; forward read strobes and data, run watchdog
// GAP   | forced inter-frame idle of IFG_CYCLES cycles
module udp_tx_arbiter #(
   parameter int unsigned NUM_REQ    = 2,
   parameter logic [15:0] MAX_LEN    = 16'd1472,
   parameter int unsigned IFG_CYCLES = 12,
   parameter logic [31:0] TIMEOUT    = 32'd100000
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [16*NUM_REQ-1:0]   req_len,
   input  logic [16*NUM_REQ-1:0]   req_port,
   input  logic [32*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]      req_rd,
   output logic [NUM_REQ-1:0]      gnt,
   output logic [NUM_REQ-1:0]      done,
   output logic [NUM_REQ-1:0]      err,
   output logic                    send_en,
   output logic [15:0]             send_data_num,
   output logic [15:0]             send_dest_port,
   output logic [31:0]             send_data,
   input  logic                    read_data_req,
   input  logic                    send_end
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;
   localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(IFG_CYCLES - 1);
   localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);
   localparam logic [31:0]        WDOG_TC  = TIMEOUT - 32'd1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_START,
      ST_BUSY,
      ST_GAP
   } state_t;

   state_t             state_q;
   logic [IDX_W-1:0]   rr_ptr_q;
   logic [IDX_W-1:0]   idx_q;
   logic [NUM_REQ-1:0] gnt_q;
   logic [NUM_REQ-1:0] done_q;
   logic [NUM_REQ-1:0] err_q;
   logic               send_en_q;
   logic [15:0]        len_q;
   logic [15:0]        port_q;
   logic [31:0]        wdog_q;
   logic [GAP_W-1:0]   gap_q;

   logic [15:0] len_a  [NUM_REQ];
   logic [15:0] port_a [NUM_REQ];
   logic [31:0] data_a [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
      assign len_a[g]  = req_len[16*g +: 16];
      assign port_a[g] = req_port[16*g +: 16];
      assign data_a[g] = req_data[32*g +: 32];
   end

   // Round-robin pick: lowest set bit at or above rr_ptr, else lowest set bit overall.
   logic               hi_found;
   logic               any_req;
   logic [IDX_W-1:0]   hi_idx;
   logic [IDX_W-1:0]   lo_idx;
   logic [IDX_W-1:0]   pick_idx;

   always_comb begin
      hi_found = 1'b0;
      any_req  = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req[j]) begin
            any_req = 1'b1;
            lo_idx  = IDX_W'(j);
            if (IDX_W'(j) >= rr_ptr_q) begin
               hi_found = 1'b1;
               hi_idx   = IDX_W'(j);
            end
         end
      end
      pick_idx = hi_found ? hi_idx : lo_idx;
   end

   logic [15:0]        pick_len;
   logic [15:0]        pick_port;
   logic [NUM_REQ-1:0] pick_oh;
   logic [IDX_W-1:0]   rr_next;
   logic               len_bad;

   assign pick_len  = len_a[pick_idx];
   assign pick_port = port_a[pick_idx];
   assign pick_oh   = ONE << pick_idx;
   assign rr_next   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
   assign len_bad   = (pick_len == 16'd0) || (pick_len > MAX_LEN);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         idx_q     <= '0;
         gnt_q     <= '0;
         done_q    <= '0;
         err_q     <= '0;
         send_en_q <= 1'b0;
         len_q     <= '0;
         port_q    <= '0;
         wdog_q    <= '0;
         gap_q     <= '0;
      end else begin
         done_q    <= '0;
         err_q     <= '0;
         send_en_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (|req) state_q <= ST_ARB;
            end
            ST_ARB: begin
               // A request withdrawn before arbitration simply returns to IDLE.
               if (!any_req) begin
                  state_q <= ST_IDLE;
               end else begin
                  idx_q    <= pick_idx;
                  len_q    <= pick_len;
                  port_q   <= pick_port;
                  rr_ptr_q <= rr_next;
                  if (len_bad) begin
                     err_q   <= pick_oh;
                     gap_q   <= GAP_LOAD;
                     state_q <= ST_GAP;
                  end else begin
                     gnt_q   <= pick_oh;
                     state_q <= ST_START;
                  end
               end
            end
            ST_START: begin
               send_en_q <= 1'b1;
               wdog_q    <= '0;
               state_q   <= ST_BUSY;
            end
            ST_BUSY: begin
               // send_end is checked first so it wins over a coincident watchdog expiry.
               if (send_end) begin
                  done_q  <= gnt_q;
                  gnt_q   <= '0;
                  gap_q   <= GAP_LOAD;
                  state_q <= ST_GAP;
               end else if (wdog_q == WDOG_TC) begin
                  err_q   <= gnt_q;
                  gnt_q   <= '0;
                  gap_q   <= GAP_LOAD;
                  state_q <= ST_GAP;
               end else begin
                  wdog_q <= wdog_q + 32'd1;
               end
            end
            ST_GAP: begin
               if (gap_q == '0) state_q <= ST_IDLE;
               else             gap_q   <= gap_q - GAP_W'(1);
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign gnt            = gnt_q;
   assign done           = done_q;
   assign err            = err_q;
   assign send_en        = send_en_q;
   assign send_data_num  = len_q;
   assign send_dest_port = port_q;
   assign req_rd         = (state_q == ST_BUSY && read_data_req) ? gnt_q : '0;
   assign send_data      = (|gnt_q) ? data_a[idx_q] : 32'd0;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed + randomized bench for udp_tx_arbiter; a round-robin pointer model and
// per-source tables supply every expected value.
module tb_udp_tx_arbiter;

   localparam int N    = 2;
   localparam int IFG  = 12;
   localparam int TMO  = 50;
   localparam int MAXL = 1472;

   logic           sys_clk = 1'b0;
   logic           sys_rst = 1'b1;
   logic [N-1:0]   req = '0;
   logic [16*N-1:0] req_len = '0;
   logic [16*N-1:0] req_port = '0;
   logic [32*N-1:0] req_data = '0;
   logic [N-1:0]   req_rd, gnt, done, err;
   logic           send_en;
   logic [15:0]    send_data_num, send_dest_port;
   logic [31:0]    send_data;
   logic           read_data_req = 1'b0;
   logic           send_end = 1'b0;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          m_rr    = 0;
   int          exp_len  [N];
   int          exp_port [N];
   logic [31:0] exp_data [N];

   udp_tx_arbiter #(
      .NUM_REQ(N), .MAX_LEN(16'd1472), .IFG_CYCLES(IFG), .TIMEOUT(32'd50)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req), .req_len(req_len),
      .req_port(req_port), .req_data(req_data), .req_rd(req_rd), .gnt(gnt),
      .done(done), .err(err), .send_en(send_en), .send_data_num(send_data_num),
      .send_dest_port(send_dest_port), .send_data(send_data),
      .read_data_req(read_data_req), .send_end(send_end)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   function automatic bit len_ok(input int l);
      return (l >= 1) && (l <= MAXL);
   endfunction

   // Next grant: first requester at or after the pointer, wrapping; pointer moves past it.
   function automatic int model_grant(input logic [N-1:0] r);
      int pick;
      pick = -1;
      for (int k = 0; k < N; k++)
         if (pick < 0 && r[(m_rr + k) % N]) pick = (m_rr + k) % N;
      if (pick >= 0) m_rr = (pick + 1) % N;
      return pick;
   endfunction

   task automatic set_src(input int i, input int len, input int port, input logic [31:0] data);
      req_len[16*i +: 16]  = 16'(len);
      req_port[16*i +: 16] = 16'(port);
      req_data[32*i +: 32] = data;
      exp_len[i]  = len;
      exp_port[i] = port;
      exp_data[i] = data;
   endtask

   // which: 0 waits for send_en, 1 waits for any err bit
   task automatic wait_for(input int which, input int bound, output int lat, output bit saw_en);
      lat = 0;
      saw_en = 1'b0;
      do begin
         tick();
         lat++;
         if (send_en === 1'b1 && which == 1) saw_en = 1'b1;
      end while (!((which == 0) ? (send_en === 1'b1) : (err !== '0)) && lat < bound);
   endtask

   // Engine model for one frame, starting in a BUSY cycle; send_end in relative cycle endc.
   task automatic serve(input int idx, input int nreads, input int endc);
      for (int c = 0; c <= endc; c++) begin
         if (c == 1) chk("send_en_width", send_en, 0);
         read_data_req = (c < nreads);
         send_end = (c == endc);
         #1;
         chk("req_rd", req_rd, (c < nreads) ? (64'd1 << idx) : 64'd0);
         chk("send_data", send_data, exp_data[idx]);
         tick();
      end
      read_data_req = 1'b0;
      send_end = 1'b0;
      chk("done", done, 64'd1 << idx);
      chk("err_with_done", err, 0);
      chk("gnt_drop", gnt, 0);
   endtask

   task automatic go_idle();
      req = '0;
      repeat (IFG + 2) tick();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"}, gnt, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_send_en"}, send_en, 0);
      chk({tag, "_num"}, send_data_num, 0);
      chk({tag, "_port"}, send_dest_port, 0);
      chk({tag, "_req_rd"}, req_rd, 0);
      chk({tag, "_send_data"}, send_data, 0);
   endtask

   always @(negedge sys_clk) begin
      if (!sys_rst) begin
         chk("gnt_onehot", $onehot0(gnt), 1);
         chk("done_onehot", $onehot0(done), 1);
         chk("err_onehot", $onehot0(err), 1);
         chk("done_err_excl", (|done) && (|err), 0);
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int idx, lat, nr, ec;
      bit saw;
      logic [N-1:0] r;

      // Reset
      #1;
      chk_all_zero("reset");
      tick();
      tick();
      sys_rst = 1'b0;
      m_rr = 0;
      tick();
      chk_all_zero("post_reset");

      // Single request, then the same requester again after the gap
      set_src(0, 8, 6000, 32'hA1B2C3D4);
      set_src(1, 12, 7000, 32'h0BADF00D);
      idx = model_grant(2'b01);
      req = 2'b01;
      wait_for(0, 10, lat, saw);
      chk("single_latency", lat, 3);
      chk("single_gnt", gnt, 64'd1 << idx);
      chk("single_num", send_data_num, 8);
      chk("single_port", send_dest_port, 6000);
      serve(idx, 2, 3);
      read_data_req = 1'b1;
      #1;
      chk("rd_outside_busy", req_rd, 0);
      read_data_req = 1'b0;
      send_end = 1'b1;
      tick();
      send_end = 1'b0;
      chk("end_outside_busy", done, 0);
      idx = model_grant(2'b01);
      wait_for(0, 40, lat, saw);
      chk("single_pitch", lat, 14);
      chk("single_regnt", gnt, 64'd1 << idx);
      serve(idx, 1, 2);
      go_idle();

      // Contention: both held, grants alternate starting from source 0
      sys_rst = 1'b1;
      #1;
      tick();
      sys_rst = 1'b0;
      m_rr = 0;
      set_src(0, 4, 5000, 32'h11112222);
      set_src(1, 12, 5001, 32'h33334444);
      req = 2'b11;
      for (int f = 0; f < 4; f++) begin
         idx = model_grant(2'b11);
         wait_for(0, 40, lat, saw);
         chk("cont_latency", lat, (f == 0) ? 3 : 15);
         chk("cont_gnt", gnt, (f % 2 == 0) ? 64'd1 : 64'd2);
         chk("cont_num", send_data_num, exp_len[idx]);
         chk("cont_port", send_dest_port, exp_port[idx]);
         serve(idx, 1 + f % 2, 2 + f);
      end
      go_idle();

      // Illegal lengths
      set_src(0, 0, 5100, 32'hDEAD0000);
      idx = model_grant(2'b01);
      req = 2'b01;
      wait_for(1, 10, lat, saw);
      chk("len0_latency", lat, 2);
      chk("len0_err", err, 64'd1 << idx);
      chk("len0_gnt", gnt, 0);
      chk("len0_no_send_en", saw, 0);
      idx = model_grant(2'b01);
      wait_for(1, 30, lat, saw);
      chk("len0_gap_pitch", lat, 14);
      chk("len0_err_again", err, 64'd1 << idx);
      go_idle();
      set_src(0, 1473, 5101, 32'hDEAD0001);
      idx = model_grant(2'b01);
      req = 2'b01;
      wait_for(1, 10, lat, saw);
      chk("len1473_latency", lat, 2);
      chk("len1473_err", err, 64'd1 << idx);
      chk("len1473_gnt", gnt, 0);
      chk("len1473_no_send_en", saw, 0);
      go_idle();
      set_src(0, 1472, 5102, 32'hCAFE1472);
      idx = model_grant(2'b01);
      req = 2'b01;
      wait_for(0, 10, lat, saw);
      chk("len1472_latency", lat, 3);
      chk("len1472_num", send_data_num, 1472);
      serve(idx, 2, 3);
      go_idle();

      // Timeout, then the waiting source is served with send_end at the last legal cycle
      set_src(0, 10, 4000, 32'h0000AAAA);
      set_src(1, 20, 4001, 32'h0000BBBB);
      idx = model_grant(2'b01);
      req = 2'b01;
      wait_for(0, 10, lat, saw);
      chk("tmo_latency", lat, 3);
      req = 2'b11;
      wait_for(1, TMO + 30, lat, saw);
      chk("tmo_cycles", lat, TMO);
      chk("tmo_err", err, 64'd1 << idx);
      chk("tmo_done", done, 0);
      chk("tmo_gnt", gnt, 0);
      req = 2'b10;
      idx = model_grant(2'b10);
      wait_for(0, 40, lat, saw);
      chk("tmo_next_latency", lat, 15);
      chk("tmo_next_gnt", gnt, 64'd1 << idx);
      chk("tmo_next_num", send_data_num, 20);
      serve(idx, 2, TMO - 1);
      tick();
      chk("tmo_edge_no_err", err, 0);
      go_idle();

      // Mid-frame disturbance: req dropped, len/port changed
      set_src(0, 20, 3000, 32'h12345678);
      idx = model_grant(2'b01);
      req = 2'b01;
      wait_for(0, 10, lat, saw);
      chk("dist_latency", lat, 3);
      req = 2'b00;
      set_src(0, 99, 3333, 32'h87654321);
      repeat (3) tick();
      chk("dist_num_held", send_data_num, 20);
      chk("dist_port_held", send_dest_port, 3000);
      chk("dist_gnt_held", gnt, 64'd1 << idx);
      serve(idx, 1, 3);
      chk("dist_num_after", send_data_num, 20);
      go_idle();

      // Reset mid-BUSY, then arbitration restarts from pointer 0
      set_src(0, 30, 3100, 32'hAAAA0000);
      set_src(1, 40, 3101, 32'hBBBB1111);
      idx = model_grant(2'b01);
      req = 2'b01;
      wait_for(0, 10, lat, saw);
      chk("rst_latency", lat, 3);
      tick();
      tick();
      read_data_req = 1'b1;
      #1;
      chk("rst_pre_gnt", gnt, 64'd1 << idx);
      sys_rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      tick();
      chk("rst_no_done", done, 0);
      chk("rst_no_err", err, 0);
      read_data_req = 1'b0;
      sys_rst = 1'b0;
      m_rr = 0;
      req = 2'b11;
      idx = model_grant(2'b11);
      wait_for(0, 10, lat, saw);
      chk("rst_next_latency", lat, 3);
      chk("rst_next_gnt", gnt, 64'd1 << idx);
      chk("rst_next_num", send_data_num, exp_len[idx]);
      serve(idx, 1, 2);
      go_idle();

      // Randomized frames against the pointer model
      for (int it = 0; it < 16; it++) begin
         for (int s = 0; s < N; s++) begin
            if ($urandom_range(0, 4) == 0)
               set_src(s, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1473, 1600)),
                       int'($urandom_range(1, 65535)), $urandom);
            else
               set_src(s, int'($urandom_range(1, MAXL)), int'($urandom_range(1, 65535)), $urandom);
         end
         r = N'($urandom_range(1, 3));
         idx = model_grant(r);
         req = r;
         if (len_ok(exp_len[idx])) begin
            wait_for(0, 10, lat, saw);
            chk("rnd_latency", lat, 3);
            chk("rnd_gnt", gnt, 64'd1 << idx);
            chk("rnd_num", send_data_num, exp_len[idx]);
            chk("rnd_port", send_dest_port, exp_port[idx]);
            nr = int'($urandom_range(0, 3));
            ec = nr + int'($urandom_range(0, 5));
            serve(idx, nr, ec);
         end else begin
            wait_for(1, 10, lat, saw);
            chk("rnd_err_latency", lat, 2);
            chk("rnd_err", err, 64'd1 << idx);
            chk("rnd_err_gnt", gnt, 0);
            chk("rnd_err_no_send_en", saw, 0);
         end
         go_idle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares the single UDP/IP transmit engine between NUM_REQ frame sources, for example a UDP loopback source and a status reporter.
- Grants requests round-robin and latches each granted request's length and destination port.
- Issues the engine's one-cycle send_en, steers the engine's word-read strobes and data to the granted source, and waits for send_end.
- Enforces an inter-frame gap and a watchdog timeout.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MAX_LEN, 16'd1472, largest legal UDP payload in bytes.
- IFG_CYCLES, 12, idle cycles forced after each frame before the next grant.
- TIMEOUT, 32'd100000, maximum BUSY cycles allowed before send_end is declared lost.

Ports:
- sys_clk  in  1  transmit clock.
- sys_rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  level request per source; hold high until done or err.
- req_len  in  16*NUM_REQ  payload bytes per source; slice i is bits [16i+15:16i].
- req_port  in  16*NUM_REQ  destination UDP port per source.
- req_data  in  32*NUM_REQ  payload word per source; big-endian, byte 0 in bits [31:24].
- req_rd  out  NUM_REQ  word-read strobe forwarded to the granted source.
- gnt  out  NUM_REQ  one-hot grant, high from ARB exit until frame end.
- done  out  NUM_REQ  one-cycle pulse: frame sent.
- err  out  NUM_REQ  one-cycle pulse: request rejected or timed out.
- send_en  out  1  one-cycle start pulse to the engine.
- send_data_num  out  16  latched payload length.
- send_dest_port  out  16  latched destination port.
- send_data  out  32  req_data slice of the granted source.
- read_data_req  in  1  engine word-read strobe.
- send_end  in  1  engine one-cycle end-of-frame pulse.

Behaviour:
- Reset: all outputs 0; state IDLE; rr_ptr=0; counters=0. Reset asserted mid-frame aborts immediately, with no done/err pulse.
- States:
  - IDLE -> ARB when any req bit is 1.
  - ARB, 1 cycle: select the first set req bit searching from rr_ptr upward with wrap-around. Latch idx, len and port. Set rr_ptr=idx+1 mod NUM_REQ.
  - ARB, length check: if len==0 or len>MAX_LEN, pulse err[idx] and go to GAP; no send_en is issued. Otherwise raise gnt[idx] and go to START.
  - START, 1 cycle: send_en=1, then go to BUSY.
  - BUSY: req_rd = read_data_req routed to bit idx only, combinational. send_data = req_data slice idx, combinational, at all times while gnt is high. Watchdog increments each cycle.
  - BUSY exit on send_end: pulse done[idx], drop gnt, go to GAP.
  - BUSY exit on timeout (watchdog == TIMEOUT-1 and no send_end): pulse err[idx], drop gnt, go to GAP.
  - GAP: count IFG_CYCLES cycles, then go to IDLE. A request present at that point is arbitrated on the next cycle.
- Timing:
  - Latency from req rise while IDLE to send_en: 3 cycles (IDLE, ARB, START).
  - Back-to-back frame pitch: send_end cycle + 1 + IFG_CYCLES + 3.
- Boundary rules:
  - send_end coincident with watchdog expiry: done wins; no err.
  - send_end outside BUSY is ignored.
  - read_data_req outside BUSY is not forwarded; req_rd stays 0.
  - req deasserted during START/BUSY: ignored; the frame completes and done still pulses.
  - req_len and req_port changes after ARB are ignored because the values are latched.
  - Requests from all sources held continuously: grants rotate 0,1,..,NUM_REQ-1,0. No source waits more than NUM_REQ-1 frames.
  - Single requester: it is granted repeatedly, separated by the IFG.
- Invariants: gnt, done and err are each at most one-hot; done and err never share a cycle; send_data_num and send_dest_port hold their values from START until the next ARB.

Test Plan:
- Single request: req=01, len=16'd8, port=16'd6000.
  - Required: send_en 3 cycles later with send_data_num=8 and send_dest_port=6000.
  - The engine issues 2 read_data_req, producing 2 req_rd[0] pulses.
  - send_end produces done=01 on the next edge; 12 gap cycles follow.
- Contention: req=11 held for 4 frames, with len0=4 and len1=12.
  - Required grant order: 01,10,01,10. Each send_data_num matches its source.
  - req_rd[1] is never set while gnt=01.
- Illegal length: len0=0, then len0=1473.
  - Required: err=01 pulse each time; no send_en, gnt stays 00, GAP is entered.
  - A subsequent len0=1472 request is sent normally.
- Timeout: run with TIMEOUT=32'd50 and never assert send_end.
  - Required: err pulse exactly 50 cycles after entering BUSY, gnt drops, the next request is served.
  - A second run asserts send_end in cycle 49 of BUSY: required done and no err.
- Mid-frame disturbance: drop req[0] in BUSY and change len0.
  - Required: the frame completes, done=01, send_data_num stays unchanged.
  - Then assert sys_rst mid-BUSY: required all outputs 0 asynchronously, and the next request is served from rr_ptr=0.
